// File: rtl/mul_add_p_lanes.sv
// Multi-lane codeword refresh: XORs a fresh codeword r*P into every lane of a buffered
// block, time-sharing one mul_P across lanes and pulling one RNG word per lane.
package types;
    localparam int d = 8;
endpackage

module mul_add_p_lanes #(
    parameter int d     = types::d,
    parameter int LANES = 4,
    parameter int CNT_W = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LANES-1:0][2*d-1:0] in_data,
    input  logic                      in_bypass,
    input  logic [d-1:0][2*d-1:0]     M,
    input  logic                      rnd_valid,
    output logic                      rnd_ready,
    input  logic [d-1:0]              rnd,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LANES-1:0][2*d-1:0] out_data,
    output logic                      busy,
    output logic [CNT_W-1:0]          rnd_count
);
    localparam int N  = 2 * d;
    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);

    typedef logic [N-1:0]                state_t;
    typedef logic [d-1:0]                red_poly_t;
    typedef logic [d-1:0][N-1:0]         dn_matrix_t;
    typedef logic [LANES-1:0][N-1:0]     block_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MASK = 2'd1,
        DONE = 2'd2
    } fsm_t;

    // Codeword r*P over GF(2): XOR of the matrix rows selected by the bits of r.
    function automatic state_t mul_P(input red_poly_t r, input dn_matrix_t m);
        state_t acc;
        acc = '0;
        for (int j = 0; j < d; j++) begin
            if (r[j]) acc = acc ^ m[j];
        end
        return acc;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    fsm_t             state_q, state_d;
    logic [LW-1:0]    lane_q, lane_d;
    block_t           buf_q, buf_d;
    dn_matrix_t       m_q, m_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        buf_d   = buf_q;
        m_d     = m_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    buf_d   = in_data;
                    m_d     = M;
                    lane_d  = '0;
                    state_d = in_bypass ? DONE : MASK;
                end
            end
            MASK: begin
                if (rnd_valid) begin
                    buf_d[lane_q] = buf_q[lane_q] ^ mul_P(rnd, m_q);
                    cnt_d         = sat_inc(cnt_q);
                    if (lane_q == LAST_LANE) begin
                        state_d = DONE;
                    end else begin
                        lane_d = lane_q + LW'(1);
                    end
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            lane_q  <= '0;
            buf_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
        end
    end

    // The matrix only matters while a block is in flight, so it carries no reset.
    always_ff @(posedge clk) begin
        m_q <= m_d;
    end

    assign in_ready  = (state_q == IDLE);
    assign rnd_ready = (state_q == MASK);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_data  = buf_q;
    assign rnd_count = cnt_q;

endmodule

// File: tb/tb_mul_add_p_lanes.sv
// Scoreboard bench for mul_add_p_lanes: directed blocks with hand-computed refreshed lanes.
module tb_mul_add_p_lanes;
    localparam int D  = 8;
    localparam int L  = 4;
    localparam int CW = 16;

    typedef logic [L-1:0][15:0] blk_t;
    typedef logic [D-1:0][15:0] mat_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    blk_t          in_data;
    logic          in_bypass;
    mat_t          M;
    logic          rnd_valid;
    logic          rnd_ready;
    logic [D-1:0]  rnd;
    logic          out_valid;
    logic          out_ready;
    blk_t          out_data;
    logic          busy;
    logic [CW-1:0] rnd_count;

    int   checks = 0;
    int   errors = 0;
    blk_t exp_q[$];
    logic [7:0] rw [4];
    mat_t m1, m2, m3;

    mul_add_p_lanes #(.d(D), .LANES(L), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_bypass(in_bypass), .M(M),
        .rnd_valid(rnd_valid), .rnd_ready(rnd_ready), .rnd(rnd),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .rnd_count(rnd_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rw(input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] c, input logic [7:0] e);
        rw[0] = a; rw[1] = b; rw[2] = c; rw[3] = e;
    endtask

    // Presents a block in IDLE for one edge, then scrambles M/in_data to prove they were latched.
    task automatic start(input blk_t data, input mat_t m, input logic byp);
        in_data   = data;
        M         = m;
        in_bypass = byp;
        in_valid  = 1'b1;
        chk("in_ready_idle", in_ready, 1);
        cyc();
        in_valid  = 1'b0;
        in_bypass = 1'b0;
        M         = ~m;
        in_data   = ~data;
    endtask

    // Delivers rw[0..3], optionally dropping rnd_valid for stall_len cycles before lane stall_at.
    task automatic feed(input int stall_at, input int stall_len);
        for (int i = 0; i < L; i++) begin
            if (i == stall_at) begin
                for (int s = 0; s < stall_len; s++) begin
                    rnd_valid = 1'b0;
                    rnd       = 8'hEE;
                    chk("stall_no_out", out_valid, 0);
                    cyc();
                end
            end
            rnd_valid = 1'b1;
            rnd       = rw[i];
            chk("rnd_ready_mask", rnd_ready, 1);
            if (i == L - 1) chk("out_valid_early", out_valid, 0);
            cyc();
        end
        rnd_valid = 1'b0;
        rnd       = 8'h00;
    endtask

    // Monitor: pops the scoreboard on every output handshake.
    initial begin
        blk_t e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected got=%h want=none", out_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_data", out_data, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int j = 0; j < D; j++) begin
            m1[j] = 16'h0101 << j;
            m2[j] = 16'h0001 << (2 * j);
            m3[j] = 16'hFFFF >> j;
        end
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_bypass = 1'b0; M = '0;
        rnd_valid = 1'b0; rnd = '0; out_ready = 1'b1;

        cyc(); cyc();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_rnd_ready", rnd_ready, 0);
        chk("rst_rnd_count", rnd_count, 0);
        chk("rst_out_data", out_data, 0);
        rst = 1'b0;
        cyc();

        // Zero randomness leaves the data untouched.
        exp_q.push_back({16'hFFFF, 16'h0000, 16'h3C3C, 16'hA5A5});
        set_rw(8'h00, 8'h00, 8'h00, 8'h00);
        start({16'hFFFF, 16'h0000, 16'h3C3C, 16'hA5A5}, m1, 1'b0);
        chk("busy_mask", busy, 1);
        chk("in_ready_mask", in_ready, 0);
        feed(-1, 0);
        chk("zero_lat4", out_valid, 1);
        chk("zero_cnt", rnd_count, 4);
        cyc();

        // Codeword add with m1: r*P = {r, r}.
        exp_q.push_back({16'h210F, 16'h1A3C, 16'h5779, 16'h486E});
        set_rw(8'h5A, 8'h01, 8'h80, 8'hFF);
        start({16'hDEF0, 16'h9ABC, 16'h5678, 16'h1234}, m1, 1'b0);
        feed(-1, 0);
        chk("cw_lat4", out_valid, 1);
        chk("cw_cnt", rnd_count, 8);
        cyc();

        // Bypass with randomness constantly offered.
        exp_q.push_back({16'h0004, 16'h0003, 16'h0002, 16'h0001});
        rnd_valid = 1'b1;
        rnd       = 8'hFF;
        start({16'h0004, 16'h0003, 16'h0002, 16'h0001}, m1, 1'b1);
        chk("byp_lat1", out_valid, 1);
        chk("byp_rnd_ready", rnd_ready, 0);
        chk("byp_cnt", rnd_count, 8);
        cyc();
        chk("byp_rnd_ready_idle", rnd_ready, 0);
        chk("byp_cnt_after", rnd_count, 8);
        rnd_valid = 1'b0;

        // RNG stall of 3 cycles after lane 1, with m3: adjacent bits j,j+1 give bit 15-j.
        exp_q.push_back({16'h4555, 16'h8AAA, 16'hB0F0, 16'h8F0F});
        set_rw(8'h03, 8'h06, 8'h0C, 8'h18);
        start({16'h5555, 16'hAAAA, 16'hF0F0, 16'h0F0F}, m3, 1'b0);
        feed(2, 3);
        chk("stall_lat7", out_valid, 1);
        chk("stall_cnt", rnd_count, 12);
        cyc();

        // Backpressure in DONE with m2: bit j of r lands at bit 2j.
        out_ready = 1'b0;
        exp_q.push_back({16'h2322, 16'h1144, 16'hBFFE, 16'h5555});
        set_rw(8'hFF, 8'h81, 8'h0F, 8'h10);
        start({16'h2222, 16'h1111, 16'hFFFF, 16'h0000}, m2, 1'b0);
        feed(-1, 0);
        chk("bp_lat4", out_valid, 1);
        rnd_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            chk("bp_hold_data", out_data, {16'h2322, 16'h1144, 16'hBFFE, 16'h5555});
            chk("bp_in_ready", in_ready, 0);
            chk("bp_rnd_ready", rnd_ready, 0);
            cyc();
        end
        out_ready = 1'b1;
        rnd_valid = 1'b0;
        cyc();
        chk("bp_idle_in_ready", in_ready, 1);
        chk("bp_idle_out_valid", out_valid, 0);
        chk("bp_cnt", rnd_count, 16);

        // Reset after two lanes discards the block; next block starts from lane 0.
        start({16'h2222, 16'h1111, 16'hFFFF, 16'h0000}, m2, 1'b0);
        rnd_valid = 1'b1;
        rnd = 8'hFF; cyc();
        rnd = 8'h81; cyc();
        rst = 1'b1;
        rnd = 8'h0F; cyc();
        rst = 1'b0;
        rnd_valid = 1'b0;
        chk("mrst_out_valid", out_valid, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_cnt", rnd_count, 0);
        chk("mrst_in_ready", in_ready, 1);
        chk("mrst_rnd_ready", rnd_ready, 0);
        chk("mrst_out_data", out_data, 0);

        exp_q.push_back({16'h210F, 16'h1A3C, 16'h5779, 16'h486E});
        set_rw(8'h5A, 8'h01, 8'h80, 8'hFF);
        start({16'hDEF0, 16'h9ABC, 16'h5678, 16'h1234}, m1, 1'b0);
        feed(-1, 0);
        chk("post_rst_lat4", out_valid, 1);
        chk("post_rst_cnt", rnd_count, 4);
        cyc();
        chk("post_rst_idle", in_ready, 1);

        cyc();
        chk("sb_drain", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mul_add_p_lanes.md
# mul_add_p_lanes

Sequential, multi-lane codeword refresh unit for the CLM masked datapath. Accepts a block of LANES masked states and adds an independent random codeword r·P to each lane. A single shared mul_P instance is time-multiplexed across lanes, and fresh randomness is pulled from the RNG over a valid/ready stream. It sits between the masked round logic and the state register, wherever a full-state re-randomisation is needed, and has a per-block bypass mode.

## Interface
Parameters:
- d, package default (types::d) — code parameter forwarded to mul_P; fixes state_t / red_poly_t / dn_matrix_t widths.
- LANES, 4 — state words per block (≥1).
- CNT_W, 16 — width of the randomness-consumption counter.

Ports:
- clk  in  1  — single clock; all logic is rising-edge.
- rst  in  1  — synchronous, active-high reset.
- in_valid  in  1  — input block valid.
- in_ready  out  1  — unit can accept a block.
- in_data  in  LANES×state_t  — masked input states; lane i = in_data[i].
- in_bypass  in  1  — 1: pass the block unchanged, consume no randomness.
- M  in  dn_matrix_t  — encoding matrix; latched with the block.
- rnd_valid  in  1  — RNG word valid.
- rnd_ready  out  1  — unit consumes an RNG word this cycle.
- rnd  in  red_poly_t  — randomness word r.
- out_valid  out  1  — output block valid.
- out_ready  in  1  — downstream accepts the output.
- out_data  out  LANES×state_t  — refreshed states.
- busy  out  1  — high in every state except IDLE.
- rnd_count  out  CNT_W  — saturating count of RNG words consumed since reset.

## Operation
- FSM states: IDLE, MASK, DONE.
- IDLE: in_ready=1.
  - On in_valid, latch in_data into buf[0..LANES-1] and latch M and in_bypass.
  - Lane index lane←0.
  - Next state is DONE if in_bypass=1, otherwise MASK.
- MASK: rnd_ready=1, in_ready=0.
  - On rnd_valid: buf[lane] ← buf[lane] ^ mul_P(rnd, M_latched); rnd_count increments, saturating at 2^CNT_W−1.
  - If lane==LANES−1, go to DONE; otherwise lane++.
  - If rnd_valid=0, hold: no buffer or lane change.
- DONE: out_valid=1 and out_data=buf.
  - On out_ready, go to IDLE.
  - out_data is stable while out_valid=1 and out_ready=0.
- Lanes are processed strictly in order 0..LANES−1. One RNG word per lane, never reused.
- in_bypass=1: rnd_ready stays 0 for the whole block and rnd_count does not change.
- M and rnd are sampled only in their respective consume cycles. Changes to M after acceptance do not affect the block in flight.
- in_ready is 0 whenever busy=1, so at most one block is in flight.
- Arithmetic: XOR only. mul_P is used as a combinational function on the registered M and the live rnd; its output is stored in the same cycle.

## Timing
- Reset (rst=1 at an edge), from any state including mid-MASK or DONE:
  - state←IDLE, lane←0, buf←0, rnd_count←0.
  - Next cycle: out_valid=0, rnd_ready=0, busy=0, in_ready=1, out_data=0.
  - A partial block is discarded; no randomness is consumed in the reset cycle.
- Latency, accept edge to out_valid:
  - LANES cycles with continuous rnd_valid, each stall cycle adding exactly one.
  - 1 cycle in bypass.
- Throughput: one block per LANES+2 cycles with out_ready=1 and continuous randomness. The next in_valid is accepted in the IDLE cycle that follows the output handshake.
- Handshakes complete only when valid and ready are both high at the same edge. valid must not depend combinationally on ready; in_ready and rnd_ready are pure functions of state.

## Test plan
- Zero randomness: LANES=4, in_data lanes = 'hA5.., 'h3C.., 'h00.., 'hFF.. with rnd=0 every cycle. Required: out_data==in_data, out_valid exactly 4 cycles after accept, rnd_count=4.
- Codeword add: random M and random r0..r3. Required: out_data[i]^in_data[i] == mul_P(r_i, M) per the golden model, in lane order; a second block gives rnd_count=8.
- Bypass: in_bypass=1 with rnd_valid held 1. Required: rnd_ready stays 0, out_data==in_data 1 cycle after accept, rnd_count unchanged.
- RNG stall: drop rnd_valid for 3 cycles after lane 1. Required: out_valid delayed exactly 3 cycles and lanes 2–3 use the 3rd and 4th delivered words.
- Backpressure: out_ready=0 for 5 cycles in DONE. Required: out_data stable, in_ready=0, rnd_ready=0, then IDLE one cycle after out_ready=1.
- Reset mid-MASK: rst after 2 lanes. Required: next cycle out_valid=0, busy=0, rnd_count=0, in_ready=1; the following block processes correctly from lane 0.
